// File: rtl/add8u_err_pkg.sv
// Shared types and width helpers for the approximate-adder error monitors.
package add8u_err_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Adder result width for W-bit operands.
  function automatic int unsigned sum_w(input int unsigned w);
    return w + 1;
  endfunction

  // Error-count width: enough for 2^(2W) pairs.
  function automatic int unsigned cnt_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

  // Error-sum width: 2^(2W) pairs times at most 2^(W+1)-1 each.
  function automatic int unsigned acc_w(input int unsigned w);
    return 3 * w + 1;
  endfunction

endpackage

// File: rtl/abs_diff_u.sv
// Combinational unsigned absolute difference |x - y| over N bits.
module abs_diff_u #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] diff_c
);

  always_comb begin
    diff_c = (x >= y) ? (x - y) : (y - x);
  end

endmodule

// File: rtl/add8u_err_monitor.sv
// Exhaustive operand sweep for an external adder, with a two-stage
// sample/accumulate pipeline producing SAE, WCE (with first pair) and error count.
module add8u_err_monitor
  import add8u_err_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [W-1:0]            op_a,
  output logic [W-1:0]            op_b,
  output logic                    op_valid,
  input  logic [sum_w(W)-1:0]     dut_sum,
  output logic                    busy,
  output logic                    done,
  output logic [acc_w(W)-1:0]     sae,
  output logic [sum_w(W)-1:0]     wce,
  output logic [W-1:0]            wce_a,
  output logic [W-1:0]            wce_b,
  output logic [cnt_w(W)-1:0]     err_cnt
);

  localparam int unsigned SW = sum_w(W);
  localparam int unsigned CW = 2 * W;
  localparam int unsigned EW = cnt_w(W);
  localparam int unsigned AW = acc_w(W);

  state_t        state, state_nxt;
  logic [CW-1:0] pair, pair_nxt;
  logic          valid_nxt, busy_nxt, done_nxt;
  logic          clr_c;

  logic          s1_valid;
  logic [W-1:0]  s1_a, s1_b;
  logic [SW-1:0] s1_exact, s1_dut;
  logic [SW-1:0] err_c;

  // Pair counter doubles as the operand register; it wraps to 0 after the last pair.
  assign op_a = pair[W-1:0];
  assign op_b = pair[CW-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pair     <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pair     <= pair_nxt;
      op_valid <= valid_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pair_nxt  = pair;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    clr_c     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SWEEP;
          pair_nxt  = '0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          clr_c     = 1'b1;
        end else begin
          done_nxt  = (state == DONE);
        end
      end
      SWEEP: begin
        pair_nxt = pair + CW'(1);
        busy_nxt = 1'b1;
        if (pair == '1) begin
          state_nxt = DRAIN;
        end else begin
          valid_nxt = 1'b1;
        end
      end
      DRAIN: begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage 1: capture the presented pair, its exact sum and the adder's answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_exact <= '0;
      s1_dut   <= '0;
    end else begin
      s1_valid <= op_valid;
      s1_a     <= op_a;
      s1_b     <= op_b;
      s1_exact <= SW'(op_a) + SW'(op_b);
      s1_dut   <= dut_sum;
    end
  end

  abs_diff_u #(
    .N (SW)
  ) u_abs_diff (
    .x      (s1_exact),
    .y      (s1_dut),
    .diff_c (err_c)
  );

  // Stage 2: accumulate; strict compare keeps the earliest worst-case pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sae     <= '0;
      wce     <= '0;
      wce_a   <= '0;
      wce_b   <= '0;
      err_cnt <= '0;
    end else if (clr_c) begin
      sae     <= '0;
      wce     <= '0;
      wce_a   <= '0;
      wce_b   <= '0;
      err_cnt <= '0;
    end else if (s1_valid) begin
      sae     <= sae + AW'(err_c);
      err_cnt <= err_cnt + EW'(err_c != '0);
      if (err_c > wce) begin
        wce   <= err_c;
        wce_a <= s1_a;
        wce_b <= s1_b;
      end
    end
  end

endmodule

// File: tb/tb_add8u_err_monitor.sv
// Bench for add8u_err_monitor at W=2: fixed fault tables, random adder LUTs
// against a pair-by-pair reference model, and reset/restart sequences.
module tb_add8u_err_monitor;

  localparam int unsigned W = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         op_valid;
  logic [W:0]   dut_sum;
  logic         busy, done;
  logic [3*W:0] sae;
  logic [W:0]   wce;
  logic [W-1:0] wce_a, wce_b;
  logic [2*W:0] err_cnt;

  int           mode;
  logic [47:0]  lut_bits;
  int           n_chk = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  add8u_err_monitor #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .dut_sum(dut_sum),
    .busy(busy), .done(done), .sae(sae), .wce(wce),
    .wce_a(wce_a), .wce_b(wce_b), .err_cnt(err_cnt)
  );

  // Adder under test behaviours: 0 exact, 1 zero, 2 xor-1, 3 single fault, 4 LUT.
  function automatic int dutf(input int m, input int a, input int b, input logic [47:0] lut);
    int exact;
    exact = a + b;
    case (m)
      0: return exact;
      1: return 0;
      2: return exact ^ 1;
      3: return (a == 2 && b == 1) ? 0 : exact;
      default: return int'(lut[(b * 4 + a) * 3 +: 3]);
    endcase
  endfunction

  always_comb dut_sum = 3'(dutf(mode, int'(op_a), int'(op_b), lut_bits));

  // Reference statistics over the first n pairs in sweep order (A fastest).
  function automatic void model(input int m, input logic [47:0] lut, input int n,
                                output int s, output int w, output int wa,
                                output int wb, output int cnt);
    int a, b, e, d;
    s = 0; w = 0; wa = 0; wb = 0; cnt = 0;
    for (int idx = 0; idx < n; idx++) begin
      a = idx % 4;
      b = idx / 4;
      d = dutf(m, a, b, lut);
      e = (a + b > d) ? (a + b - d) : (d - (a + b));
      s += e;
      if (e != 0) cnt++;
      if (e > w) begin w = e; wa = a; wb = b; end
    end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input int s, input int w, input int wa,
                           input int wb, input int cnt);
    chk({tag, " sae"}, longint'(sae), longint'(s));
    chk({tag, " wce"}, longint'(wce), longint'(w));
    chk({tag, " wce_a"}, longint'(wce_a), longint'(wa));
    chk({tag, " wce_b"}, longint'(wce_b), longint'(wb));
    chk({tag, " err_cnt"}, longint'(err_cnt), longint'(cnt));
  endtask

  // Start a sweep and run until done (bounded); cycle 1 is the first after the accepting edge.
  task automatic run_sweep(input bit hold, output int done_cycle, output int vcyc,
                           output int bcyc, output bit seq_ok, output bit lat_ok);
    int c, n, s, w, wa, wb, cnt;
    vcyc = 0; bcyc = 0; seq_ok = 1'b1; lat_ok = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    c = 1;
    while (!done && c < 60) begin
      if (op_valid) begin
        if (int'(op_a) != vcyc % 4 || int'(op_b) != vcyc / 4) seq_ok = 1'b0;
        vcyc++;
      end
      if (busy) bcyc++;
      n = (c - 2 < 0) ? 0 : ((c - 2 > 16) ? 16 : c - 2);
      model(mode, lut_bits, n, s, w, wa, wb, cnt);
      if (int'(sae) != s || int'(err_cnt) != cnt) lat_ok = 1'b0;
      @(negedge clk);
      c++;
    end
    done_cycle = done ? c : -1;
  endtask

  typedef struct {
    int m;
    int s;
    int w;
    int wa;
    int wb;
    int cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dc, vc, bc, s, w, wa, wb, cnt;
    bit sq, lt;

    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 48, 6, 3, 3, 15};
    vecs[2] = '{2, 16, 1, 0, 0, 16};
    vecs[3] = '{3, 3, 3, 2, 1, 1};

    rst_n = 1'b0; start = 1'b0; mode = 0; lut_bits = '0;
    repeat (3) @(negedge clk);
    chk("rst op_a", longint'(op_a), 0);
    chk("rst op_b", longint'(op_b), 0);
    chk("rst op_valid", longint'(op_valid), 0);
    chk("rst busy", longint'(busy), 0);
    chk("rst done", longint'(done), 0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].m;
      run_sweep(1'b0, dc, vc, bc, sq, lt);
      chk($sformatf("vec%0d done_cycle", i), longint'(dc), 18);
      chk($sformatf("vec%0d valid_cycles", i), longint'(vc), 16);
      chk($sformatf("vec%0d busy_cycles", i), longint'(bc), 17);
      chk($sformatf("vec%0d operand_seq", i), longint'(sq), 1);
      chk($sformatf("vec%0d latency", i), longint'(lt), 1);
      chk_stats($sformatf("vec%0d", i), vecs[i].s, vecs[i].w, vecs[i].wa, vecs[i].wb, vecs[i].cnt);
      @(negedge clk);
      chk($sformatf("vec%0d done_hold", i), longint'(done), 1);
      chk($sformatf("vec%0d op_valid_after", i), longint'(op_valid), 0);
    end

    for (int r = 0; r < 3; r++) begin
      mode = 4;
      for (int k = 0; k < 16; k++) lut_bits[k * 3 +: 3] = 3'($urandom_range(0, 7));
      run_sweep(1'b0, dc, vc, bc, sq, lt);
      model(4, lut_bits, 16, s, w, wa, wb, cnt);
      chk($sformatf("rnd%0d done_cycle", r), longint'(dc), 18);
      chk($sformatf("rnd%0d latency", r), longint'(lt), 1);
      chk_stats($sformatf("rnd%0d", r), s, w, wa, wb, cnt);
    end

    // Mid-sweep start is ignored; reset at cycle 8 discards everything.
    mode = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("mid op_a_c4", longint'(op_a), 3);
    chk("mid op_b_c4", longint'(op_b), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid op_valid", longint'(op_valid), 0);
    chk("mid busy", longint'(busy), 0);
    chk("mid op_a", longint'(op_a), 0);
    chk("mid op_b", longint'(op_b), 0);
    chk_stats("mid", 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid idle busy", longint'(busy), 0);
    chk("mid idle done", longint'(done), 0);
    mode = 3;
    run_sweep(1'b0, dc, vc, bc, sq, lt);
    chk("post_rst done_cycle", longint'(dc), 18);
    chk_stats("post_rst", 3, 3, 2, 1, 1);

    // start held through DONE restarts at once and repeats the result.
    mode = 1;
    run_sweep(1'b1, dc, vc, bc, sq, lt);
    chk("held done_cycle", longint'(dc), 18);
    chk_stats("held first", 48, 6, 3, 3, 15);
    @(negedge clk);
    chk("held done_drop", longint'(done), 0);
    chk("held busy", longint'(busy), 1);
    chk("held sae_clr", longint'(sae), 0);
    chk("held cnt_clr", longint'(err_cnt), 0);
    start = 1'b0;
    dc = 0;
    while (!done && dc < 40) begin
      @(negedge clk);
      dc++;
    end
    chk("held second done", longint'(done), 1);
    chk_stats("held second", 48, 6, 3, 3, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
